if_fetch_unit: RTL

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit_if.sv | 29 ++
 rtl/if_fetch_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/if_fetch_unit_if.sv
// SRAM-like instruction fetch bus between the fetch unit and the bridge.
interface if_fetch_unit_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  // Fetch unit side: issues requests, consumes handshakes and data.
  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  // Bridge side.
  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC sequencing, single-outstanding SRAM-like fetch,
// IF/ID presentation with stall/flush/jump redirection.
module if_fetch_unit (
  input  logic                cpu_clk_50M,
  input  logic                cpu_rst_n,
  input  logic [3:0]          stall,
  input  logic                flush,
  input  logic [31:0]         flush_pc,
  input  logic                jump_flag,
  input  logic [31:0]         jump_addr,
  if_fetch_unit_if.master     bus,
  output logic [31:0]         if_pc,
  output logic [31:0]         inst_o,
  output logic [4:0]          if_exccode,
  output logic                stallreq_if
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned EXC_W = 5;

  localparam logic [XLEN-1:0]  PC_RESET = 32'hBFC0_0000;
  localparam logic [XLEN-1:0]  PC_STEP  = 32'd4;
  localparam logic [EXC_W-1:0] EXC_NONE = 5'h10;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'h04;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t          r_state, w_state_n;
  logic [XLEN-1:0] r_pc, w_pc_n;
  logic [XLEN-1:0] r_buf, w_buf_n;
  logic            r_discard, w_discard_n;
  logic            r_pend_vld, w_pend_vld_n;
  logic [XLEN-1:0] r_pend_addr, w_pend_addr_n;

  logic            w_misal;
  logic            w_beat;
  logic            w_req;
  logic            w_avail;
  logic            w_outstanding;
  logic [1:0]      w_unused_stall;

  // Upper stall bits belong to later stages.
  assign w_unused_stall = stall[3:2];

  // Fetch status decode.
  assign w_misal = (r_pc[1:0] != 2'b00);
  assign w_beat  = (r_state == S_WAIT) && bus.inst_data_ok && !r_discard;
  assign w_req   = (r_state == S_REQ) && !w_misal && !r_discard;
  assign w_avail = ((r_state != S_IDLE) && w_misal) || w_beat || (r_state == S_HOLD);
  // A bridge transaction will still be in flight after this edge.
  assign w_outstanding = ((r_state == S_WAIT) && !bus.inst_data_ok)
                       || (w_req && bus.inst_addr_ok)
                       || (r_discard && !bus.inst_data_ok);

  // Bus and IF/ID outputs; the returning beat bypasses the buffer.
  assign bus.inst_req  = w_req;
  assign bus.inst_addr = r_pc;
  assign if_pc         = r_pc;
  assign inst_o        = w_misal ? '0 : (w_beat ? bus.inst_rdata : r_buf);
  assign if_exccode    = w_misal ? EXC_ADEL : EXC_NONE;
  assign stallreq_if   = ((r_state == S_REQ) || (r_state == S_WAIT)) && !w_avail;

  // State, PC and side registers.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= PC_RESET;
      r_buf       <= '0;
      r_discard   <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
    end else begin
      r_state     <= w_state_n;
      r_pc        <= w_pc_n;
      r_buf       <= w_buf_n;
      r_discard   <= w_discard_n;
      r_pend_vld  <= w_pend_vld_n;
      r_pend_addr <= w_pend_addr_n;
    end
  end

  // Next-state: flush first, then delivery/advance, then request handshake.
  always_comb begin
    w_state_n     = r_state;
    w_pc_n        = r_pc;
    w_buf_n       = r_buf;
    w_discard_n   = r_discard;
    w_pend_vld_n  = r_pend_vld;
    w_pend_addr_n = r_pend_addr;

    if (r_state == S_IDLE) begin
      w_state_n = S_REQ;
    end else if (flush) begin
      w_pc_n       = flush_pc;
      w_state_n    = S_REQ;
      w_discard_n  = w_outstanding;
      w_pend_vld_n = 1'b0;
    end else begin
      if (r_discard && bus.inst_data_ok) begin
        w_discard_n = 1'b0;
      end
      if (w_beat) begin
        w_buf_n = bus.inst_rdata;
      end
      if (w_avail) begin
        if (stall[1] || stall[0]) begin
          w_state_n = S_HOLD;
        end else begin
          if (jump_flag) begin
            w_pc_n = jump_addr;
          end else if (r_pend_vld) begin
            w_pc_n = r_pend_addr;
          end else begin
            w_pc_n = XLEN'(r_pc + PC_STEP);
          end
          w_pend_vld_n = 1'b0;
          w_state_n    = S_REQ;
        end
      end else begin
        if (w_req && bus.inst_addr_ok) begin
          w_state_n = S_WAIT;
        end
        // Redirect seen while the fetch is incomplete is applied at the next advance.
        if (jump_flag) begin
          w_pend_vld_n  = 1'b1;
          w_pend_addr_n = jump_addr;
        end
      end
    end
  end

endmodule
